soc_iomem: RTL and testbench
============================

# soc_iomem

Memory-mapped I/O peripheral block for the risky SoC. It sits behind the processor's memory bus next to the RAM and is selected when the address falls in the I/O window. It replaces the single write-only LED register with a parametrised register file containing:
- an LED output register of configurable width
- a UART transmitter with busy status
- a free-running, loadable cycle timer

It also adds registered read-back, so firmware can poll status.

## Interface
Parameters:
- XLEN, 32: bus data/address width.
- NUM_LEDS, 4: LED output width, 1..32.
- ADDR_BITS, 22: low address bits decoded inside the I/O window.
- BAUD_DIV, 16: clk cycles per UART bit, ≥2.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- sel  input  1  high when the current bus access targets I/O space (driven from address bit 22 by the SoC).
- mem_addr  input  XLEN  byte address; only [ADDR_BITS-1:0] decoded.
- mem_wdata  input  XLEN  write data.
- mem_wmask  input  4  byte-lane write enables; any bit set = write strobe.
- mem_rstrb  input  1  read strobe.
- io_rdata  output  XLEN  registered read data.
- leds  output  NUM_LEDS  LED register value.
- uart_tx  output  1  serial line, idle high.

## Operation
Register map (offset = mem_addr[ADDR_BITS-1:0]; every other offset is unmapped):
- 0x04 LEDS, RW: bits [NUM_LEDS-1:0]; upper bits read 0.
- 0x08 UART_DATA, WO: a write with mem_wmask[0]=1 while not busy latches wdata[7:0] and starts a frame. A write while busy is dropped silently. Reads return 0.
- 0x0C TIMER, RW: 32-bit counter, +1 every cycle.
- 0x10 STATUS, RO: bit0 = uart_busy; other bits 0.

Write behaviour:
- A write occurs when sel & |mem_wmask. Writes with sel=0 are ignored.
- LEDS and TIMER honour byte lanes: lane n updates bits [8n+7:8n]. LEDS lanes above NUM_LEDS are ignored.
- TIMER update priority: a write replaces the increment for that cycle, and only the written lanes change. Unwritten lanes keep their pre-increment value. Otherwise the counter wraps 0xFFFF_FFFF → 0.
- Writes to unmapped offsets or RO registers have no effect.

Read behaviour:
- A read occurs when sel & mem_rstrb. io_rdata is loaded with the addressed register, or 0 if unmapped.
- io_rdata holds its value until the next read; it is not cleared between reads.

UART FSM, states IDLE → START → DATA → STOP → IDLE:
- IDLE: uart_tx=1, busy=0. An accepted write goes to START, with shift register = byte and bit counter = 0.
- START: uart_tx=0 for BAUD_DIV cycles.
- DATA: 8 bits, LSB first, each held BAUD_DIV cycles; bit counter 0..7.
- STOP: uart_tx=1 for BAUD_DIV cycles, then IDLE.
- busy=1 in every state except IDLE.
- The baud counter counts 0..BAUD_DIV-1 and restarts on each state or bit change.

Reset:
- io_rdata=0, leds=0, uart_tx=1, busy=0, TIMER=0, FSM=IDLE.
- Reset mid-frame aborts the frame: uart_tx returns high on the next cycle.

## Timing
- Writes take effect at the posedge ending the strobe cycle, so new register values are visible from the next cycle.
- Read latency is 1 cycle: io_rdata is valid the cycle after mem_rstrb, matching RAM read latency.
- A TIMER read returns the count at the strobe edge, i.e. the value before that edge's increment.
- A read and a write to the same register in one cycle return the old value.
- An accepted UART_DATA write sets busy from the next cycle. uart_tx falls on that same cycle.
- A frame is exactly 10×BAUD_DIV cycles; busy clears the cycle after the last STOP cycle.
- Back-to-back frames: a new write is accepted the first cycle STATUS.busy reads 0. The minimum start-to-start spacing is 10×BAUD_DIV+1 cycles.

## Test plan
- Reset, then idle: leds=0, uart_tx=1, io_rdata=0. TIMER read after 100 cycles from reset release → 99 or 100, checked exactly against a model.
- LEDS write with 0xFFFF_FFF5 and mask 0xF, NUM_LEDS=4 → leds=0x5, read-back 0x0000_0005. Same write with sel=0 → leds unchanged.
- UART send 0xA5, BAUD_DIV=4:
  - uart_tx sequence is 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles.
  - STATUS.bit0 = 1 for 40 cycles.
  - A second write of 0x3C mid-frame is dropped, and the line is unchanged.
- TIMER write 0xFFFF_FFFE with mask 0xF → reads 0xFFFF_FFFF then 0x0000_0000 on consecutive cycles (wrap). Write 0xAB with mask 0x1 → only byte 0 replaced.
- Assert reset at DATA bit 3 → uart_tx=1 and busy=0 next cycle. A new write then starts a clean frame.
- Reads of offsets 0x00, 0x14 and 0x08 → io_rdata=0. Writes there change no register.

Source files
------------

// File: rtl/soc_iomem_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_iomem_if
// Brief    : Processor-side bus bundle between the SoC and the I/O block.
// Revision : 1.0 - initial release
// ============================================================================
interface soc_iomem_if #(
    parameter int XLEN     = 32,
    parameter int NUM_LEDS = 4
);
    logic                sel;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [3:0]          mem_wmask;
    logic                mem_rstrb;
    logic [XLEN-1:0]     io_rdata;
    logic [NUM_LEDS-1:0] leds;
    logic                uart_tx;

    modport master (
        output sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  io_rdata, leds, uart_tx
    );

    modport slave (
        input  sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output io_rdata, leds, uart_tx
    );
endinterface
`default_nettype wire

// File: rtl/soc_iomem.sv
`default_nettype none
// ============================================================================
// Module   : soc_iomem
// Brief    : Memory-mapped I/O register file: LEDs, UART transmitter, timer.
// Revision : 1.0 - initial release
// ============================================================================
module soc_iomem #(
    parameter int XLEN      = 32,
    parameter int NUM_LEDS  = 4,
    parameter int ADDR_BITS = 22,
    parameter int BAUD_DIV  = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    soc_iomem_if.slave  bus
);

    localparam logic [ADDR_BITS-1:0] c_OFF_LEDS   = ADDR_BITS'('h04);
    localparam logic [ADDR_BITS-1:0] c_OFF_UART   = ADDR_BITS'('h08);
    localparam logic [ADDR_BITS-1:0] c_OFF_TIMER  = ADDR_BITS'('h0C);
    localparam logic [ADDR_BITS-1:0] c_OFF_STATUS = ADDR_BITS'('h10);
    localparam int                   c_BAUD_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_BAUD_W-1:0]  c_BAUD_LAST  = c_BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    uart_state_t          r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [2:0]           r_bitcnt;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic [NUM_LEDS-1:0]  r_leds;
    logic [31:0]          r_timer;
    logic [XLEN-1:0]      r_rdata;

    logic [ADDR_BITS-1:0] w_off;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_leds_wr;
    logic                 w_timer_wr;
    logic                 w_uart_start;
    logic [31:0]          w_timer_inc;
    logic [31:0]          w_timer_next;
    logic [NUM_LEDS-1:0]  w_leds_next;
    logic [XLEN-1:0]      w_rdata;

    assign w_off        = bus.mem_addr[ADDR_BITS-1:0];
    assign w_wr         = bus.sel & (|bus.mem_wmask);
    assign w_rd         = bus.sel & bus.mem_rstrb;
    assign w_leds_wr    = w_wr && (w_off == c_OFF_LEDS);
    assign w_timer_wr   = w_wr && (w_off == c_OFF_TIMER);
    assign w_uart_start = w_wr && (w_off == c_OFF_UART) && bus.mem_wmask[0]
                          && (r_state == S_IDLE);
    assign w_timer_inc  = r_timer + 32'd1;

    // A timer write suppresses the increment; unwritten lanes keep the old count.
    generate
        for (genvar n = 0; n < 4; n++) begin : g_timer_lanes
            assign w_timer_next[8*n +: 8] = w_timer_wr
                ? (bus.mem_wmask[n] ? bus.mem_wdata[8*n +: 8] : r_timer[8*n +: 8])
                : w_timer_inc[8*n +: 8];
        end
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led_bits
            assign w_leds_next[i] = (w_leds_wr && bus.mem_wmask[i/8])
                                    ? bus.mem_wdata[i] : r_leds[i];
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_LEDS:   w_rdata[NUM_LEDS-1:0] = r_leds;
            c_OFF_TIMER:  w_rdata[31:0]         = r_timer;
            c_OFF_STATUS: w_rdata[0]            = r_busy;
            default:      w_rdata               = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds  <= '0;
            r_timer <= '0;
            r_rdata <= '0;
        end else begin
            r_leds  <= w_leds_next;
            r_timer <= w_timer_next;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Line level and busy are registered alongside the state so they change
    // on the same edge as the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_uart_start) begin
                        r_state  <= S_START;
                        r_shift  <= bus.mem_wdata[7:0];
                        r_bitcnt <= '0;
                        r_baud   <= '0;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.io_rdata = r_rdata;
    assign bus.leds     = r_leds;
    assign bus.uart_tx  = r_tx;

    logic w_unused;
    assign w_unused = &{1'b0, bus.mem_addr[XLEN-1:ADDR_BITS]};

endmodule
`default_nettype wire

// File: tb/tb_soc_iomem.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_iomem
// Brief    : Directed plus random bus traffic against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_iomem;

    localparam int c_BAUD = 4;
    localparam int c_NLED = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    soc_iomem_if #(.XLEN(32), .NUM_LEDS(c_NLED)) bus ();

    soc_iomem #(
        .XLEN(32), .NUM_LEDS(c_NLED), .ADDR_BITS(22), .BAUD_DIV(c_BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: timer is an affine function of cycle number; a frame is a start
    // cycle plus a byte, and the line level is looked up from elapsed time.
    int          now;
    logic [3:0]  m_leds;
    logic [31:0] m_rdata;
    logic [31:0] m_tbase;
    int          m_tstart;
    bit          m_fvalid;
    int          m_fs;
    logic [7:0]  m_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    function automatic logic [31:0] timer_at(input int t);
        return m_tbase + 32'(t - m_tstart);
    endfunction

    function automatic logic busy_at(input int t);
        return m_fvalid && (t >= m_fs) && (t < m_fs + 10 * c_BAUD);
    endfunction

    function automatic logic tx_at(input int t);
        logic [9:0] fr;
        if (!busy_at(t)) return 1'b1;
        fr = {1'b1, m_byte, 1'b0};
        return fr[(t - m_fs) / c_BAUD];
    endfunction

    task automatic check_outputs();
        check("leds",    32'(bus.leds),    32'(m_leds));
        check("rdata",   bus.io_rdata,     m_rdata);
        check("uart_tx", 32'(bus.uart_tx), 32'(tx_at(now)));
    endtask

    task automatic step(input logic s, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic rs);
        logic [31:0] cur;
        logic [31:0] nt;
        logic [21:0] off;
        bus.sel = s; bus.mem_addr = a; bus.mem_wdata = wd;
        bus.mem_wmask = wm; bus.mem_rstrb = rs;
        cur = timer_at(now);
        off = a[21:0];
        if (s && rs) begin
            case (off)
                22'h04:  m_rdata = {28'b0, m_leds};
                22'h0C:  m_rdata = cur;
                22'h10:  m_rdata = {31'b0, busy_at(now)};
                default: m_rdata = 32'h0;
            endcase
        end
        if (s && (wm != 4'h0)) begin
            case (off)
                22'h04: if (wm[0]) m_leds = wd[3:0];
                22'h0C: begin
                    nt = cur;
                    for (int n = 0; n < 4; n++) if (wm[n]) nt[8*n +: 8] = wd[8*n +: 8];
                    m_tbase  = nt;
                    m_tstart = now + 1;
                end
                22'h08: if (wm[0] && !busy_at(now)) begin
                    m_fvalid = 1'b1;
                    m_fs     = now + 1;
                    m_byte   = wd[7:0];
                end
                default: ;
            endcase
        end
        @(posedge clk);
        now++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.sel = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.mem_wmask = '0; bus.mem_rstrb = 1'b0;
        @(posedge clk);
        now = 0; m_leds = '0; m_rdata = '0; m_tbase = '0; m_tstart = 0;
        m_fvalid = 1'b0; m_fs = 0; m_byte = '0;
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        int   busy_cnt;
        int   exp_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [21:0] offs[6] = '{22'h00, 22'h04, 22'h08, 22'h0C, 22'h10, 22'h14};

        now = 0;
        do_reset();
        check("reset_tx", 32'(bus.uart_tx), 32'h1);

        // Timer read 100 cycles after reset release
        while (now < 100) idle(1);
        step(1'b1, 32'h0040_000C, 32'h0, 4'h0, 1'b1);
        check("timer100", bus.io_rdata, 32'd100);

        // LEDS write, read-back, and deselected write
        step(1'b1, 32'h0040_0004, 32'hFFFF_FFF5, 4'hF, 1'b0);
        check("leds_wr", 32'(bus.leds), 32'h5);
        step(1'b1, 32'h0040_0004, 32'h0, 4'h0, 1'b1);
        check("leds_rd", bus.io_rdata, 32'h0000_0005);
        step(1'b0, 32'h0000_0004, 32'hFFFF_FFFA, 4'hF, 1'b0);
        check("leds_nosel", 32'(bus.leds), 32'h5);

        // UART 0xA5: line sequence and busy duration
        step(1'b1, 32'h0040_0008, 32'h0000_00A5, 4'h1, 1'b0);
        check("tx_k0", 32'(bus.uart_tx), 32'(exp_seq[0]));
        busy_cnt = 0;
        for (int j = 0; j < 45; j++) begin
            step(1'b1, 32'h0040_0010, 32'h0, 4'h0, 1'b1);
            busy_cnt += int'(bus.io_rdata[0]);
            if (j + 1 < 40)
                check("tx_seq", 32'(bus.uart_tx), 32'(exp_seq[(j + 1) / c_BAUD]));
            else
                check("tx_idle", 32'(bus.uart_tx), 32'h1);
        end
        check("busy_cycles", 32'(busy_cnt), 32'd40);

        // Mid-frame write is dropped
        step(1'b1, 32'h0040_0008, 32'h0000_00A5, 4'h1, 1'b0);
        idle(12);
        step(1'b1, 32'h0040_0008, 32'h0000_003C, 4'hF, 1'b0);
        idle(40);

        // Timer wrap and per-lane writes
        step(1'b1, 32'h0040_000C, 32'hFFFF_FFFE, 4'hF, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step(1'b1, 32'h0040_000C, 32'h0, 4'h0, 1'b1);
        check("timer_ff", bus.io_rdata, 32'hFFFF_FFFF);
        step(1'b1, 32'h0040_000C, 32'h0, 4'h0, 1'b1);
        check("timer_wrap", bus.io_rdata, 32'h0000_0000);
        step(1'b1, 32'h0040_000C, 32'h1234_56FF, 4'hF, 1'b0);
        step(1'b1, 32'h0040_000C, 32'h0000_00AB, 4'h1, 1'b1);
        check("timer_rdwr_old", bus.io_rdata, 32'h1234_56FF);
        step(1'b1, 32'h0040_000C, 32'h0, 4'h0, 1'b1);
        check("timer_lane0", bus.io_rdata, 32'h1234_56AB);

        // Reset during DATA bit 3, then a clean frame
        step(1'b1, 32'h0040_0008, 32'h0000_005A, 4'h1, 1'b0);
        idle(17);
        do_reset();
        check("abort_tx", 32'(bus.uart_tx), 32'h1);
        step(1'b1, 32'h0040_0010, 32'h0, 4'h0, 1'b1);
        check("abort_busy", bus.io_rdata, 32'h0);
        step(1'b1, 32'h0040_0008, 32'h0000_003C, 4'h1, 1'b0);
        idle(42);

        // Unmapped and write-only reads; writes to unmapped/RO offsets
        step(1'b1, 32'h0040_0004, 32'hFFFF_FFF9, 4'h1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h0040_0004, 32'h0, 4'h0, 1'b1);
            step(1'b1, {10'h001, (k == 0) ? 22'h00 : (k == 1) ? 22'h14 : 22'h08},
                 32'h0, 4'h0, 1'b1);
            check("unmapped_rd", bus.io_rdata, 32'h0);
        end
        step(1'b1, 32'h0040_0000, 32'hFFFF_FFF0, 4'hF, 1'b0);
        step(1'b1, 32'h0040_0014, 32'hFFFF_FFF0, 4'hF, 1'b0);
        step(1'b1, 32'h0040_0010, 32'hFFFF_FFF0, 4'hF, 1'b0);
        check("unmapped_wr_leds", 32'(bus.leds), 32'h9);
        step(1'b1, 32'h0040_000C, 32'h0, 4'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [21:0] off;
            off = offs[$urandom_range(0, 5)];
            step(($urandom_range(0, 7) != 0),
                 {10'($urandom), off},
                 $urandom,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
